// File: rtl/sensor_sample_buf.sv
// sensor_sample_buf: captures sensor words into a DEPTH-entry buffer and
// raises a level interrupt when it is full. The CPU reads entries through a
// combinational read port and rearms the buffer with sctrl_clear.
//
// Handshake: sensor_ready is a valid-only qualifier with no backpressure.
// A sample on sensor_out is accepted on every rising edge where the block is
// in CAPTURE (sensor_en=1), sensor_ready=1 and sctrl_clear=0. In IDLE and FULL
// sensor_ready is ignored.
module sensor_sample_buf #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic [ADDR_W-1:0] sctrl_addr,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out,
  output logic              sctrl_interrupt,
  output logic [DATA_W-1:0] sctrl_out,
  output logic              sensor_en,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wptr_q, wptr_d;
  logic                wr_en;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // State and write-pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
    end
  end

  // Next-state, pointer update and write strobe; clear beats every other event.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    wr_en   = 1'b0;
    if (sctrl_clear) begin
      state_d = IDLE;
      wptr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sctrl_en) state_d = CAPTURE;
        end
        CAPTURE: begin
          if (sensor_ready) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + (ADDR_W+1)'(1);
          end
          // A write that fills the last entry wins over a falling enable so
          // the pointer never sits at DEPTH outside of FULL.
          if (sensor_ready && (wptr_q == (ADDR_W+1)'(DEPTH-1))) begin
            state_d = FULL;
          end else if (!sctrl_en) begin
            state_d = IDLE;
          end
        end
        FULL: begin
          state_d = FULL;
        end
        default: begin
          state_d = IDLE;
          wptr_d  = '0;
        end
      endcase
    end
  end

  // Sample storage: zeroed by reset, untouched by clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= sensor_out;
    end
  end

  // Combinational read port and outputs decoded from registered state.
  always_comb begin
    sctrl_out       = mem_q[sctrl_addr];
    sensor_en       = (state_q == CAPTURE);
    sctrl_interrupt = (state_q == FULL);
    dbg_state_o     = state_q;
  end

endmodule

// File: tb/tb_sensor_sample_buf.sv
// Directed bench for sensor_sample_buf: reset, full fill, clear from full,
// pause/resume, clear priority and mid-capture reset.
module tb_sensor_sample_buf;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic              sctrl_en;
  logic              sctrl_clear;
  logic [ADDR_W-1:0] sctrl_addr;
  logic              sensor_ready;
  logic [DATA_W-1:0] sensor_out;
  logic              sctrl_interrupt;
  logic [DATA_W-1:0] sctrl_out;
  logic              sensor_en;
  logic [1:0]        dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  sensor_sample_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_addr      (sctrl_addr),
    .sensor_ready    (sensor_ready),
    .sensor_out      (sensor_out),
    .sctrl_interrupt (sctrl_interrupt),
    .sctrl_out       (sctrl_out),
    .sensor_en       (sensor_en),
    .dbg_state_o     (dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
    sctrl_addr = ADDR_W'(addr);
    #1;
    check($sformatf("%s[%0d]", tag, addr), sctrl_out, exp);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sctrl_en = 1'b0; sctrl_clear = 1'b0;
    sctrl_addr = '0; sensor_ready = 1'b0; sensor_out = '0;

    // ---- Reset ----
    step(); step();
    check("rst_sensor_en", sensor_en, 1'b0);
    check("rst_irq", sctrl_interrupt, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) read_check("rst_mem", i, 32'h0);
    // Ready while idle must not write.
    sensor_ready = 1'b1; sensor_out = 32'hAAAA; step();
    check("idle_ignores_ready", sensor_en, 1'b0);
    read_check("idle_no_write", 0, 32'h0);

    // ---- Full capture ----
    sctrl_en = 1'b1; sensor_ready = 1'b1; sensor_out = 32'h1000;
    step();
    check("fill_en_rise", sensor_en, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0)
        check($sformatf("fill_busy_%0d", i), {30'd0, sctrl_interrupt, sensor_en}, 32'h1);
      sensor_out = 32'h1000 + 32'(i);
      step();
    end
    check("fill_irq", sctrl_interrupt, 1'b1);
    check("fill_en_drop", sensor_en, 1'b0);
    check("fill_state", dbg_state, ST_FULL);
    sensor_out = 32'hFFFF; step(); step();
    for (int i = 0; i < DEPTH; i++) read_check("fill_mem", i, 32'h1000 + 32'(i));
    check("full_hold_irq", sctrl_interrupt, 1'b1);

    // ---- Clear from FULL ----
    sensor_ready = 1'b0; sctrl_clear = 1'b1; step();
    check("clrfull_irq", sctrl_interrupt, 1'b0);
    check("clrfull_en", sensor_en, 1'b0);
    read_check("clrfull_keep", 5, 32'h1005);
    sctrl_clear = 1'b0; step();
    check("clrfull_rearm", sensor_en, 1'b1);
    sensor_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sensor_out = 32'h2000 + 32'(i);
      step();
    end
    sensor_ready = 1'b0;
    check("refill_irq", sctrl_interrupt, 1'b1);
    read_check("refill_mem", 0, 32'h2000);
    read_check("refill_mem", 63, 32'h203F);

    // ---- Pause/resume ----
    sctrl_clear = 1'b1; step();
    sctrl_clear = 1'b0; step();
    check("pause_start", sensor_en, 1'b1);
    sensor_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sensor_out = 32'h3000 + 32'(i);
      step();
    end
    sctrl_en = 1'b0; sensor_out = 32'h300A; step();
    check("pause_en_drop", sensor_en, 1'b0);
    read_check("pause_last", 10, 32'h300A);
    read_check("pause_first", 0, 32'h3000);
    sensor_out = 32'h5555; step();
    read_check("pause_no_write", 11, 32'h200B);
    sensor_ready = 1'b0; sctrl_en = 1'b1; step();
    check("resume_en", sensor_en, 1'b1);
    sensor_ready = 1'b1; sensor_out = 32'hBEEF;
    sctrl_addr = 6'd11; #1;
    check("same_cycle_old", sctrl_out, 32'h200B);
    step();
    sensor_ready = 1'b0;
    read_check("resume_mem", 11, 32'hBEEF);

    // ---- Clear priority ----
    sctrl_clear = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("clr_hold_%0d", i), sensor_en, 1'b0);
    end
    sctrl_clear = 1'b0; step();
    sensor_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sensor_out = 32'h4000 + 32'(i);
      step();
    end
    sctrl_clear = 1'b1; sensor_out = 32'hDEAD; step();
    check("clrpri_en", sensor_en, 1'b0);
    read_check("clrpri_no_write", 5, 32'h3005);
    sctrl_clear = 1'b0; sensor_ready = 1'b0; step();
    check("clrpri_rearm", sensor_en, 1'b1);
    sensor_ready = 1'b1; sensor_out = 32'h7777; step();
    sensor_ready = 1'b0;
    read_check("clrpri_addr0", 0, 32'h7777);
    for (int i = 1; i < 5; i++) read_check("clrpri_keep", i, 32'h4000 + 32'(i));

    // ---- Mid-operation reset ----
    sctrl_clear = 1'b1; step();
    sctrl_clear = 1'b0; step();
    sensor_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sensor_out = 32'h6000 + 32'(i);
      step();
    end
    read_check("prerst_mem", 29, 32'h601D);
    rst = 1'b1; sensor_out = 32'h9999; step();
    rst = 1'b0; sensor_ready = 1'b0; sctrl_en = 1'b0;
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_en", sensor_en, 1'b0);
    check("midrst_irq", sctrl_interrupt, 1'b0);
    for (int i = 0; i < DEPTH; i++) read_check("midrst_mem", i, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
